// File: rtl/negate_arbiter.sv
// Two-requester front end sharing one 4-bit two's-complement negate unit.
// Round-robin grant, one operation in flight, completed responses counted.
module negate_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [3:0]       req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [3:0]       req1_data,
    output logic             req1_ready,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [3:0]       resp_data,
    output logic             resp_ovf,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        RESPOND
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       last_served;
    logic       sel_id;
    logic [3:0] operand;
    logic       grant;
    logic       grant_vld;
    logic       accept;
    logic       resp_fire;

    // On a tie the requester not served last wins; otherwise the lone valid one.
    always_comb begin
        grant_vld = req0_valid | req1_valid;
        grant     = req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~last_served;
        end
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        resp_fire   = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = grant_vld & ~grant;
                req1_ready = grant_vld & grant;
                accept     = grant_vld;
                if (grant_vld) begin
                    state_nxt = COMPUTE;
                end
            end
            COMPUTE: begin
                state_nxt = RESPOND;
            end
            RESPOND: begin
                resp0_valid = ~sel_id;
                resp1_valid = sel_id;
                resp_fire   = sel_id ? resp1_ready : resp0_ready;
                if (resp_fire) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_served <= 1'b1;
            sel_id      <= 1'b0;
            operand     <= '0;
            resp_data   <= '0;
            resp_ovf    <= 1'b0;
            op_count    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                last_served <= grant;
                sel_id      <= grant;
                operand     <= grant ? req1_data : req0_data;
            end
            // Result registers are only non-zero while RESPOND is active.
            if (state == COMPUTE) begin
                resp_data <= ~operand + 4'd1;
                resp_ovf  <= (operand == 4'b1000);
            end else if (resp_fire) begin
                resp_data <= '0;
                resp_ovf  <= 1'b0;
                op_count  <= op_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_negate_arbiter.sv
// Self-checking bench for negate_arbiter against an arithmetic reference model.
module tb_negate_arbiter;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0_valid = 1'b0;
    logic [3:0]       req0_data = '0;
    logic             req0_ready;
    logic             req1_valid = 1'b0;
    logic [3:0]       req1_data = '0;
    logic             req1_ready;
    logic             resp0_valid;
    logic             resp0_ready = 1'b0;
    logic             resp1_valid;
    logic             resp1_ready = 1'b0;
    logic [3:0]       resp_data;
    logic             resp_ovf;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_last  = 1;
    int m_count = 0;

    always #5 clk = ~clk;

    negate_arbiter #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_data(resp_data), .resp_ovf(resp_ovf),
        .busy(busy), .op_count(op_count)
    );

    function automatic int neg4(input int x);
        return (16 - x) % 16;
    endfunction

    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req0_valid = 1'b0; req1_valid = 1'b0;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        rst_n = 1'b0;
        wait_edge();
        wait_edge();
        rst_n = 1'b1;
        m_last = 1;
        m_count = 0;
        wait_edge();
    endtask

    // One full transaction: arbitration, compute cycle, respond with optional stall.
    task automatic do_op(input bit v0, input int d0, input bit v1, input int d1, input int stall);
        int g, opnd, other_d;
        req0_valid = v0; req0_data = 4'(d0);
        req1_valid = v1; req1_data = 4'(d1);
        #1;
        g = (v0 && v1) ? ((m_last == 1) ? 0 : 1) : (v1 ? 1 : 0);
        checks++;
        if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin
            errors++;
            $display("FAIL grant: ready0=%b ready1=%b expected grant=%0d", req0_ready, req1_ready, g);
        end
        wait_edge();
        m_last = g;
        opnd = (g == 1) ? d1 : d0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0 ||
            resp0_valid !== 1'b0 || resp1_valid !== 1'b0 || resp_data !== 4'd0 || resp_ovf !== 1'b0) begin
            errors++;
            $display("FAIL compute: busy=%b rdy=%b%b rv=%b%b data=%h ovf=%b expected busy=1 rest 0",
                     busy, req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data, resp_ovf);
        end
        wait_edge();
        for (int i = 0; i <= stall; i++) begin
            checks++;
            if (resp0_valid !== (g == 0) || resp1_valid !== (g == 1) ||
                resp_data !== 4'(neg4(opnd)) || resp_ovf !== (opnd == 8) ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL respond: rv=%b%b data=%h ovf=%b rdy=%b%b expected served=%0d data=%h ovf=%b",
                         resp0_valid, resp1_valid, resp_data, resp_ovf, req0_ready, req1_ready,
                         g, 4'(neg4(opnd)), (opnd == 8));
            end
            if (i < stall) begin
                // Other requester waits; the unserved channel's ready must be ignored.
                other_d = $urandom_range(0, 15);
                if (g == 1) begin req0_valid = 1'b1; req0_data = 4'(other_d); resp0_ready = 1'b1; end
                else        begin req1_valid = 1'b1; req1_data = 4'(other_d); resp1_ready = 1'b1; end
                wait_edge();
            end
        end
        resp0_ready = (g == 0);
        resp1_ready = (g == 1);
        wait_edge();
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        m_count = (m_count + 1) % (1 << CNT_W);
        #1;
        checks++;
        if (op_count !== CNT_W'(m_count) || busy !== 1'b0 || resp_data !== 4'd0 ||
            resp_ovf !== 1'b0 || resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL complete: op_count=%0d busy=%b data=%h ovf=%b rv=%b%b expected count=%0d rest 0",
                     op_count, busy, resp_data, resp_ovf, resp0_valid, resp1_valid, m_count);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data, resp_ovf, busy, op_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data, resp_ovf, busy, op_count});
        end
        apply_reset();
    endtask

    task automatic test_reset_mid_op();
        req0_valid = 1'b1; req0_data = 4'd5;
        wait_edge();
        req0_valid = 1'b0;
        wait_edge();
        checks++;
        if (resp0_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_setup: resp0_valid=%b expected 1", resp0_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({resp0_valid, resp1_valid, resp_data, resp_ovf, busy, op_count} !== '0) begin
            errors++;
            $display("FAIL midreset_async: got %b expected all zero",
                     {resp0_valid, resp1_valid, resp_data, resp_ovf, busy, op_count});
        end
        wait_edge();
        rst_n = 1'b1;
        m_last = 1; m_count = 0;
        for (int i = 0; i < 4; i++) begin
            wait_edge();
            checks++;
            if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0 || busy !== 1'b0 || op_count !== '0) begin
                errors++;
                $display("FAIL midreset_after: rv=%b%b busy=%b op_count=%0d expected 0 0 0 0",
                         resp0_valid, resp1_valid, busy, op_count);
            end
        end
    endtask

    task automatic test_single();
        do_op(1'b1, 3, 1'b0, 0, 0);
    endtask

    task automatic test_tie_round_robin();
        do_op(1'b1, 1, 1'b1, 7, 0);
        do_op(1'b1, 1, 1'b1, 7, 0);
        do_op(1'b1, 2, 1'b1, 9, 0);
    endtask

    task automatic test_boundary();
        do_op(1'b1, 8, 1'b0, 0, 0);
        do_op(1'b0, 0, 1'b1, 0, 0);
        do_op(1'b1, 15, 1'b0, 0, 0);
    endtask

    task automatic test_idle_no_request();
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_edge();
            checks++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_none: ready=%b%b busy=%b expected 0 0 0", req0_ready, req1_ready, busy);
            end
        end
    endtask

    task automatic test_backpressure();
        do_op(1'b0, 0, 1'b1, 6, 5);
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_next: ready0=%b ready1=%b expected 1 0", req0_ready, req1_ready);
        end
        do_op(1'b1, 4, 1'b0, 0, 0);
    endtask

    task automatic test_counter_wrap();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            do_op(1'b1, i + 1, 1'b0, 0, 0);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int sel;
            sel = $urandom_range(1, 3);
            do_op(sel[0], $urandom_range(0, 15), sel[1], $urandom_range(0, 15), $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_op();
        test_single();
        test_tie_round_robin();
        test_boundary();
        test_idle_no_request();
        test_backpressure();
        test_counter_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/negate_arbiter.md
NEGATE_ARBITER -- requirements
Module: negate_arbiter

Interface
REQ-001 Parameter CNT_W, default 8: width of the completed-operation counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1  requester 0/1 has an operand pending.
REQ-005 req0_data / req1_data  input  4  operand for requester 0/1.
REQ-006 req0_ready / req1_ready  output  1  block accepts requester 0/1 operand this cycle.
REQ-007 resp0_valid / resp1_valid  output  1  result for requester 0/1 is presented.
REQ-008 resp0_ready / resp1_ready  input  1  requester 0/1 takes the result this cycle.
REQ-009 resp_data  output  4  two's-complement negation result, shared by both response channels.
REQ-010 resp_ovf  output  1  operand was 4'b1000, whose negation is not representable.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 op_count  output  CNT_W  count of completed responses.

Function
REQ-013 The block SHALL share one internal 4-bit negate unit (bitwise invert plus 1, modulo 16) between two requesters.
REQ-014 The FSM SHALL have three states: IDLE, COMPUTE and RESPOND.
REQ-015 State transitions:
- IDLE -> COMPUTE on a valid&ready transfer.
- COMPUTE -> RESPOND unconditionally after one cycle.
- RESPOND -> IDLE on resp_valid&resp_ready of the served channel.
REQ-016 In IDLE, reqN_ready SHALL equal (grant==N) combinationally; in all other states both ready outputs SHALL be 0.
REQ-017 At most one reqN_ready and at most one respN_valid SHALL be high in any cycle.
REQ-018 Grant with one valid: the valid requester. Grant with both valid: the requester not served last. Grant with none valid: no ready asserted.
REQ-019 A last-served pointer SHALL update on acceptance; after reset it SHALL indicate requester 1, so requester 0 wins the first tie.
REQ-020 On acceptance, the block SHALL latch the operand and requester id.
REQ-021 In COMPUTE, the block SHALL register resp_data = (~operand + 1) modulo 16, and resp_ovf = (operand == 4'b1000).
REQ-022 Latency: for an acceptance at edge N, respN_valid SHALL be high after edge N+1. Minimum throughput is one operation per 3 cycles.
REQ-023 In RESPOND, the served respN_valid, resp_data and resp_ovf SHALL hold stable until respN_ready is high. The other channel's resp_ready SHALL be ignored.
REQ-024 reqN_valid SHALL be ignored in COMPUTE and RESPOND. A requester deasserting valid before acceptance SHALL lose nothing.
REQ-025 op_count SHALL increment by 1 on each RESPOND -> IDLE transition and wrap from 2^CNT_W-1 to 0.
REQ-026 resp_data and resp_ovf SHALL be 0 outside RESPOND.

Reset
REQ-027 While rst_n = 0, the block SHALL immediately force state = IDLE, last-served = requester 1, all ready/valid outputs = 0, resp_data = 0, resp_ovf = 0, busy = 0, op_count = 0.
REQ-028 Reset asserted in COMPUTE or RESPOND SHALL discard the in-flight operation without counting it. After release, the first rising edge SHALL behave as IDLE.

Verification
REQ-029 Reset and single request:
- Reset -> all outputs 0.
- Release, req0_valid = 1 with data 0011 -> req0_ready = 1 in the same cycle.
- Two edges later: resp0_valid = 1, resp_data = 1101, resp_ovf = 0.
- resp0_ready = 1 -> op_count = 1, busy = 0.
REQ-030 Tie and round-robin:
- req0 = 0001 and req1 = 0111 held valid together -> served req0 first (1111), then req1 (1001).
- A new tie after that -> req0 served first.
REQ-031 Boundary operands:
- 1000 -> resp_data = 1000, resp_ovf = 1.
- 0000 -> resp_data = 0000, resp_ovf = 0.
- 1111 -> resp_data = 0001, resp_ovf = 0.
REQ-032 Backpressure: resp1_ready held 0 for 5 cycles with req0_valid = 1 -> resp1_valid and resp_data stable, req0_ready = 0 throughout; req0 is accepted in the cycle after the resp1 handshake.
REQ-033 Reset mid-operation: rst_n pulsed low during RESPOND -> outputs 0 immediately, op_count unchanged at 0, no response after release.
REQ-034 Counter wrap: with CNT_W = 2, four completed operations -> op_count reads 1, 2, 3, 0.
